// File: rtl/exe_pkg.sv
// Shared opcode constants and FSM state type for the EXE pipeline stage.
package exe_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_SGT  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_AND  = 6'h05;
  localparam logic [5:0] OP_XOR  = 6'h06;
  localparam logic [5:0] OP_SHL  = 6'h07;
  localparam logic [5:0] OP_BEQZ = 6'b110100;
  localparam logic [5:0] OP_BNEZ = 6'b110101;

  // opcode[IMM_BIT] selects the immediate as operand b
  localparam int IMM_BIT = 4;
  // opcode[5:2] pattern that selects next PC as operand a
  localparam logic [3:0] NPC_SEL = 4'b1101;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exe_state_t;

  function automatic logic is_mul_op(input logic [5:0] op);
    return !op[5] && (op[3:0] == OP_MUL[3:0]);
  endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: XLEN/MUL_CYCLES multiplier bits per cycle.
// With MUL_CYCLES=1 the product is purely combinational from a/b.
module exe_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int K  = XLEN / MUL_CYCLES;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [XLEN-1:0] mcand_reg, mplier_reg, acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic [XLEN-1:0] step_mcand, step_mplier, step_acc, partial;

  always_comb begin
    step_mcand  = (MUL_CYCLES == 1) ? a  : mcand_reg;
    step_mplier = (MUL_CYCLES == 1) ? b  : mplier_reg;
    step_acc    = (MUL_CYCLES == 1) ? '0 : acc_reg;
    partial     = '0;
    for (int j = 0; j < K; j++) begin
      if (step_mplier[j]) partial = partial + (step_mcand << j);
    end
    product = step_acc + partial;
    done    = (MUL_CYCLES == 1) ? start : (busy_reg && (cnt_reg == LAST));
  end

  // The last chunk stays un-accumulated while held, so product remains stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start && (MUL_CYCLES > 1)) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      if (cnt_reg == LAST) begin
        if (!hold) begin
          busy_reg <= 1'b0;
          cnt_reg  <= '0;
        end
      end else begin
        cnt_reg    <= cnt_reg + 1'b1;
        acc_reg    <= product;
        mcand_reg  <= mcand_reg << K;
        mplier_reg <= mplier_reg >> K;
      end
    end
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage: ALU, branch resolution and iterative multiply behind
// a valid/ready handshake on both the ID and MEM sides.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] npc_in,
  input  logic [31:0]     ir_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] b_out,
  output logic [XLEN-1:0] npc_out,
  output logic [31:0]     ir_out,
  output logic            br_taken,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  exe_state_t      state_reg, state_next;
  logic [5:0]      opcode;
  logic [XLEN-1:0] op_a, op_b, res_next, npc_next, mul_product;
  logic            br_next, ill_next;
  logic            out_free, accept, mul_start, mul_done, load_direct, load_mul;
  logic [XLEN-1:0] pend_b_reg, pend_npc_reg;
  logic [31:0]     pend_ir_reg;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = rst_n && (state_reg == IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul_op(opcode);

  assign load_direct = accept && !(is_mul_op(opcode) && (MUL_CYCLES > 1));
  assign load_mul    = (state_reg == MUL_BUSY) && mul_done && out_free;

  always_comb begin
    opcode   = ir_in[31:26];
    op_a     = (opcode[5:2] == NPC_SEL) ? npc_in : a_in;
    op_b     = opcode[IMM_BIT] ? imm_in : b_in;
    res_next = '0;
    ill_next = 1'b0;
    if (opcode[5]) begin
      res_next = op_a + op_b;
    end else begin
      case ({2'b00, opcode[3:0]})
        OP_ADD:  res_next = op_a + op_b;
        OP_SUB:  res_next = op_a - op_b;
        OP_MUL:  res_next = mul_product;
        OP_SGT:  res_next = {{(XLEN-1){1'b0}}, (op_a > op_b)};
        OP_OR:   res_next = op_a | op_b;
        OP_AND:  res_next = op_a & op_b;
        OP_XOR:  res_next = op_a ^ op_b;
        OP_SHL:  res_next = op_a << op_b[SHW-1:0];
        default: ill_next = 1'b1;
      endcase
    end
    br_next  = ((opcode == OP_BEQZ) && (a_in == '0)) ||
               ((opcode == OP_BNEZ) && (a_in != '0));
    npc_next = br_next ? res_next : npc_in;
  end

  exe_mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .hold    (!out_free),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (mul_start && (MUL_CYCLES > 1)) state_next = MUL_BUSY;
      MUL_BUSY: if (load_mul) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Side-band fields of a multi-cycle multiply wait here until its product loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_b_reg   <= '0;
      pend_npc_reg <= '0;
      pend_ir_reg  <= '0;
    end else if (mul_start) begin
      pend_b_reg   <= b_in;
      pend_npc_reg <= npc_in;
      pend_ir_reg  <= ir_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      b_out     <= '0;
      npc_out   <= '0;
      ir_out    <= '0;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_direct) begin
      out_valid <= 1'b1;
      alu_out   <= res_next;
      b_out     <= b_in;
      npc_out   <= npc_next;
      ir_out    <= ir_in;
      br_taken  <= br_next;
      illegal   <= ill_next;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      alu_out   <= mul_product;
      b_out     <= pend_b_reg;
      npc_out   <= pend_npc_reg;
      ir_out    <= pend_ir_reg;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Scoreboard bench for exe_stage_pipe (MUL_CYCLES=4) plus a MUL_CYCLES=1 instance.
module tb_exe_stage_pipe;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] b;
    logic [31:0] ir;
    logic        br;
    logic        ill;
  } exp_t;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_in, b_in, imm_in, npc_in, ir_in;
  logic [31:0] alu_out, b_out, npc_out, ir_out;
  logic        br_taken, illegal;

  logic        in_valid1, in_ready1, out_valid1;
  logic        out_ready1 = 1'b1;
  logic [31:0] alu_out1, b_out1, npc_out1, ir_out1;
  logic        br_taken1, illegal1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pushes = 0;
  int   pops = 0;
  int   dropped = 0;
  exp_t sb[$];
  exp_t held;
  bit   stall_prev = 0;
  bit   stress_on = 0;

  logic [5:0] nonmul_ops[18];
  logic [5:0] all_ops[20];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exe_stage_pipe #(.XLEN(32), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .imm_in(imm_in), .npc_in(npc_in), .ir_in(ir_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .b_out(b_out), .npc_out(npc_out), .ir_out(ir_out),
    .br_taken(br_taken), .illegal(illegal)
  );

  exe_stage_pipe #(.XLEN(32), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .imm_in(imm_in), .npc_in(npc_in), .ir_in(ir_in),
    .out_valid(out_valid1), .out_ready(out_ready1), .alu_out(alu_out1),
    .b_out(b_out1), .npc_out(npc_out1), .ir_out(ir_out1),
    .br_taken(br_taken1), .illegal(illegal1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic [31:0] npc);
    exp_t e;
    logic [5:0]  op;
    logic [31:0] x, y, r;
    logic        ill, br;
    op  = ir[31:26];
    x   = (op[5:2] == 4'b1101) ? npc : a;
    y   = op[4] ? imm : b;
    r   = 32'd0;
    ill = 1'b0;
    if (op[5]) r = x + y;
    else begin
      case (op[3:0])
        4'd0: r = x + y;
        4'd1: r = x - y;
        4'd2: r = x * y;
        4'd3: r = (x > y) ? 32'd1 : 32'd0;
        4'd4: r = x | y;
        4'd5: r = x & y;
        4'd6: r = x ^ y;
        4'd7: r = x << y[4:0];
        default: ill = 1'b1;
      endcase
    end
    br = ((op == 6'b110100) && (a == 32'd0)) || ((op == 6'b110101) && (a != 32'd0));
    e.alu = r;
    e.npc = br ? r : npc;
    e.b   = b;
    e.ir  = ir;
    e.br  = br;
    e.ill = ill;
    return e;
  endfunction

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] npc);
    logic [31:0] ir;
    ir       = {op, 26'($urandom)};
    a_in     = a;
    b_in     = b;
    imm_in   = imm;
    npc_in   = npc;
    ir_in    = ir;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(ir, a, b, imm, npc));
        pushes++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit allow_mul);
    logic [5:0]  op;
    logic [31:0] a;
    op = allow_mul ? all_ops[$urandom_range(0, 19)] : nonmul_ops[$urandom_range(0, 17)];
    a  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    send(op, a, $urandom, $urandom, $urandom & 32'hFFFF_FFFC);
  endtask

  // Edges after the accepting edge until out_valid shows, and how many of
  // those cycles had in_ready low.
  task automatic measure(output int edges, output int busy);
    edges = 0;
    busy  = 0;
    while (!out_valid && edges < 40) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue", sb.size(), 0);
    check("drain_valid_low", out_valid, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_alu", alu_out, held.alu);
        check("hold_npc", npc_out, held.npc);
        check("hold_ir", ir_out, held.ir);
        check("hold_b", b_out, held.b);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          pops++;
          check("sb_alu", alu_out, e.alu);
          check("sb_npc", npc_out, e.npc);
          check("sb_b", b_out, e.b);
          check("sb_ir", ir_out, e.ir);
          check("sb_br", br_taken, e.br);
          check("sb_ill", illegal, e.ill);
          $display("txn ir=%h alu=%h npc=%h b=%h br=%0d ill=%0d",
                   ir_out, alu_out, npc_out, b_out, br_taken, illegal);
        end
      end
      stall_prev = out_valid && !out_ready;
      held.alu = alu_out;
      held.npc = npc_out;
      held.ir  = ir_out;
      held.b   = b_out;
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    int edges, busy, t0;
    nonmul_ops = '{6'h00, 6'h01, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h10, 6'h11,
                   6'h13, 6'h17, 6'h08, 6'h1F, 6'h20, 6'h34, 6'h35, 6'h36, 6'h2B};
    for (int i = 0; i < 18; i++) all_ops[i] = nonmul_ops[i];
    all_ops[18] = 6'h02;
    all_ops[19] = 6'h12;

    rst_n = 0; in_valid = 0; in_valid1 = 0; out_ready = 1;
    a_in = 0; b_in = 0; imm_in = 0; npc_in = 0; ir_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_low", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1;
    #1;
    check("rst_in_ready_high", in_ready, 1);
    check("rst_alu", alu_out, 0);
    check("rst_npc", npc_out, 0);

    // MUL_CYCLES=1 instance: 6*7 via immediate in one cycle
    a_in = 6; b_in = 0; imm_in = 7; npc_in = 0; ir_in = {6'h12, 26'h0};
    in_valid1 = 1;
    @(negedge clk);
    check("mc1_ready", in_ready1, 1);
    @(posedge clk);
    #1;
    in_valid1 = 0;
    check("mc1_valid", out_valid1, 1);
    check("mc1_alu", alu_out1, 42);
    @(posedge clk);
    #1;
    check("mc1_drop", out_valid1, 0);

    // add, 1-cycle latency
    send(6'h00, 5, 7, 0, 32'h40);
    check("add_valid", out_valid, 1);
    check("add_alu", alu_out, 12);
    check("add_br", br_taken, 0);
    check("add_ill", illegal, 0);
    wait_drain();

    // multiply 6*imm7
    send(6'h12, 6, 0, 7, 32'h80);
    measure(edges, busy);
    check("mul_latency", edges, MC);
    check("mul_busy_cycles", busy, MC);
    check("mul_alu", alu_out, 42);
    wait_drain();

    // branches
    send(6'b110100, 0, 5, 32'h20, 32'h100);
    check("beqz_taken", br_taken, 1);
    check("beqz_npc", npc_out, 32'h120);
    send(6'b110100, 3, 5, 32'h20, 32'h100);
    check("beqz_not_taken", br_taken, 0);
    check("beqz_npc_seq", npc_out, 32'h100);

    // illegal and wrap
    send(6'b001000, 9, 9, 9, 0);
    check("illegal_flag", illegal, 1);
    check("illegal_alu", alu_out, 0);
    send(6'h00, 32'hFFFF_FFFF, 1, 0, 0);
    check("wrap_alu", alu_out, 0);
    wait_drain();

    // backpressure: 5 stalled cycles, then a stream including a multiply
    out_ready = 0;
    send(6'h01, 10, 3, 0, 0);
    fork
      begin
        send(6'h04, 32'hF0, 32'h0F, 0, 0);
        send(6'h02, 32'h1234, 32'h55, 0, 0);
        for (int i = 0; i < 4; i++) send_rand(0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    wait_drain();

    // throughput
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_rand(0);
    check("throughput", cyc - t0, 8);
    wait_drain();

    // random stress with random backpressure
    stress_on = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(1);
        stress_on = 0;
      end
      begin
        while (stress_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    wait_drain();

    // reset in the 2nd cycle of a multiply
    send(6'h00, 32'h11, 32'h22, 0, 32'h44);
    send(6'h02, 3, 9, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_alu", alu_out, 0);
    check("midrst_npc", npc_out, 0);
    check("midrst_b", b_out, 0);
    check("midrst_ir", ir_out, 0);
    check("midrst_in_ready", in_ready, 0);
    dropped += sb.size();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check("postrst_no_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end

    check("push_pop_balance", pushes, pops + dropped);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_pipe.md
EXE_STAGE_PIPE -- requirements
Module: exe_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have parameter MUL_CYCLES, default 4, multiply latency in cycles; legal values are 1..XLEN with XLEN divisible by MUL_CYCLES.
REQ-003 SHALL have ports clk input 1 (single clock, rising edge) and rst_n input 1 (asynchronous, active-low reset).
REQ-004 SHALL have in_valid input 1 and in_ready output 1, the ID-side handshake.
REQ-005 SHALL have a_in, b_in, imm_in and npc_in, each input XLEN, carrying operand A, operand B, sign-extended immediate and next PC.
REQ-006 SHALL have ir_in input 32, the instruction word; opcode is ir_in[31:26].
REQ-007 SHALL have out_valid output 1 and out_ready input 1, the MEM-side handshake.
REQ-008 SHALL have alu_out, b_out and npc_out, each output XLEN, carrying the result, forwarded B and the resolved next PC.
REQ-009 SHALL have ir_out output 32, the forwarded instruction.
REQ-010 SHALL have br_taken output 1 (branch resolved taken) and illegal output 1 (undefined opcode).

Function
REQ-011 A transfer on either side SHALL occur only on a cycle where valid and ready are both high at the clk edge.
REQ-012 Operand a SHALL be npc_in when opcode[5:2]=1101, and a_in otherwise.
REQ-013 Operand b SHALL be imm_in when opcode[4]=1, and b_in otherwise.
REQ-014 When opcode[5]=0, the result SHALL be selected by opcode[3:0]:
- 0 = a+b
- 1 = a-b
- 2 = low XLEN bits of a*b
- 3 = (a>b unsigned) ? 1 : 0
- 4 = a|b
- 5 = a&b
- 6 = a^b
- 7 = a<<b[log2(XLEN)-1:0]
REQ-015 When opcode[5]=0 and opcode[3:0] is 8..15, the result SHALL be 0 and illegal SHALL be 1 with that output.
REQ-016 When opcode[5]=1, the result SHALL be a+b (load, store and branch targets).
REQ-017 Branch condition:
- opcode 110100 (BEQZ): taken if a_in==0.
- opcode 110101 (BNEZ): taken if a_in!=0.
- All other opcodes: not taken.
REQ-018 npc_out SHALL equal the result when the branch is taken, and npc_in otherwise.
REQ-019 b_out SHALL equal b_in; ir_out SHALL equal ir_in. Both SHALL be captured at acceptance.
REQ-020 All outputs SHALL be registered; alu_out, npc_out, b_out, ir_out, br_taken and illegal SHALL change only when a new result loads.
REQ-021 Non-multiply latency SHALL be 1: out_valid rises the cycle after acceptance.
REQ-022 Multiply latency SHALL be MUL_CYCLES: out_valid rises MUL_CYCLES cycles after acceptance. The multiply SHALL be iterative shift-add over XLEN/MUL_CYCLES multiplier bits per cycle.
REQ-023 The FSM SHALL have states IDLE and MUL_BUSY.
- IDLE -> MUL_BUSY on acceptance of opcode 0x02 or 0x12.
- MUL_BUSY -> IDLE when the iteration counter reaches MUL_CYCLES-1, loading the output register in that cycle.
- With MUL_CYCLES=1 the multiply SHALL complete in IDLE at 1-cycle latency.
REQ-024 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops SHALL sustain 1 instruction per cycle.
REQ-025 Backpressure: while out_valid && !out_ready, all outputs SHALL hold stable and no new input SHALL be accepted.
REQ-026 A multiply finishing while the output is stalled SHALL remain in MUL_BUSY holding its product until the output register frees, then load.
REQ-027 Simultaneous output drain and input accept in the same cycle SHALL load the new result with no bubble.
REQ-028 out_valid SHALL fall after a drain when no new result loads.
REQ-029 Arithmetic SHALL wrap modulo 2^XLEN; no overflow flag.

Reset
REQ-030 When rst_n is low, the block SHALL asynchronously set state=IDLE, iteration counter=0, out_valid=0, br_taken=0, illegal=0, and alu_out, npc_out, b_out, ir_out all 0.
REQ-031 Reset asserted mid-multiply SHALL abandon the operation; no result SHALL appear after deassertion.
REQ-032 in_ready SHALL be 0 while rst_n is low, and SHALL be 1 on the first cycle after deassertion.

Structure
REQ-033 Opcode constants (OP_ADD..OP_SHL, OP_BEQZ, OP_BNEZ, immediate bit index) and the FSM state typedef SHALL live in the shared package exe_pkg.
REQ-034 The iterative multiplier SHALL be a sub-module exe_mul_iter, with a start/done interface, parameterised by XLEN and MUL_CYCLES.

Verification
REQ-035 Accept opcode 000000, A=5, B=7 -> next cycle out_valid=1, alu_out=12, br_taken=0, illegal=0.
REQ-036 Accept opcode 010010, A=6, imm=7 with MUL_CYCLES=4 -> in_ready=0 for 4 cycles, then alu_out=42; repeat at MUL_CYCLES=1 -> 1-cycle latency.
REQ-037 Accept opcode 110100, A=0, npc=0x100, imm=0x20 -> br_taken=1, npc_out=0x120; repeat with A=3 -> br_taken=0, npc_out=0x100.
REQ-038 Hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, no acceptance; release -> stream of 1/cycle with no lost or duplicated instruction.
REQ-039 Assert rst_n=0 on the 2nd cycle of a multiply -> all outputs 0 immediately; after release, out_valid stays 0 until the next acceptance.
REQ-040 Accept opcode 001000 -> illegal=1, alu_out=0; accept A=0xFFFFFFFF + B=1 -> alu_out=0.
